mem_port_arbiter: RTL and testbench

- N-port round-robin arbiter between CPU-side memory clients and the single client port of the memory controller.
- Generalises the fixed 2-port rw_flag/addr/data/mask/busy/done bus to PORTS clients with fair arbitration.
- Latches each granted request and holds the downstream bus stable until the controller completes.
- Returns read data per port, one transaction in flight at a time.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter of PORTS clients onto one memory controller port.
// Define MEMARB_TIMEOUT_EN to add the WAIT watchdog (TIMEOUT parameter, timeout_err output).
module mem_port_arbiter #(
  parameter int PORTS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEMARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2*PORTS-1:0]         rw_flag,
  input  logic [ADDR_W*PORTS-1:0]    addr,
  input  logic [DATA_W*PORTS-1:0]    write_data,
  input  logic [DATA_W/8*PORTS-1:0]  write_mask,
  output logic [DATA_W*PORTS-1:0]    read_data,
  output logic [PORTS-1:0]           busy,
  output logic [PORTS-1:0]           done,
  output logic [1:0]                 m_rw_flag,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_write_data,
  output logic [DATA_W/8-1:0]        m_write_mask,
  input  logic [DATA_W-1:0]          m_read_data,
  input  logic                       m_busy,
  input  logic                       m_done
`ifdef MEMARB_TIMEOUT_EN
  , output logic                     timeout_err
`endif
);
  localparam int MASK_W = DATA_W / 8;
  localparam int IW = $clog2(PORTS);
  localparam logic [IW:0] NP = (IW + 1)'(PORTS);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, idx, pos, gnt_idx;
  logic [IW:0] sum;
  logic [PORTS-1:0] req, rot;
  logic [1:0] op_a [PORTS];
  logic [ADDR_W-1:0] addr_a [PORTS];
  logic [DATA_W-1:0] wd_a [PORTS];
  logic [DATA_W-1:0] rd_a [PORTS];
  logic [MASK_W-1:0] wm_a [PORTS];
`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif
  always_comb begin
    for (int k = 0; k < PORTS; k++) begin
      op_a[k] = rw_flag[2*k +: 2];
      addr_a[k] = addr[ADDR_W*k +: ADDR_W];
      wd_a[k] = write_data[DATA_W*k +: DATA_W];
      wm_a[k] = write_mask[MASK_W*k +: MASK_W];
      req[k] = ^op_a[k];
      read_data[DATA_W*k +: DATA_W] = rd_a[k];
    end
  end
  // rotate so rr_ptr sits at bit 0, take the lowest requester, then rotate the index back
  always_comb begin
    rot = PORTS'({req, req} >> rr_ptr);
    pos = '0;
    for (int k = PORTS - 1; k >= 0; k--) if (rot[k]) pos = IW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, pos};
    gnt_idx = IW'((sum >= NP) ? sum - NP : sum);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      busy <= '0;
      done <= '0;
      m_rw_flag <= '0;
      m_addr <= '0;
      m_write_data <= '0;
      m_write_mask <= '0;
      for (int k = 0; k < PORTS; k++) rd_a[k] <= '0;
`ifdef MEMARB_TIMEOUT_EN
      cnt <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef MEMARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: if (|req && !m_busy) begin
          idx <= gnt_idx;
          busy[gnt_idx] <= 1'b1;
          m_rw_flag <= op_a[gnt_idx];
          m_addr <= addr_a[gnt_idx];
          m_write_data <= wd_a[gnt_idx];
          m_write_mask <= wm_a[gnt_idx];
          state <= ISSUE;
        end
        ISSUE: begin
`ifdef MEMARB_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
`ifdef MEMARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
          if (m_done || cnt == CW'(TIMEOUT - 1)) begin
            if (m_rw_flag == 2'b01) rd_a[idx] <= m_done ? m_read_data : '1;
            timeout_err <= !m_done;
`else
          if (m_done) begin
            if (m_rw_flag == 2'b01) rd_a[idx] <= m_read_data;
`endif
            m_rw_flag <= '0;
            busy[idx] <= 1'b0;
            done[idx] <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (idx == IW'(PORTS - 1)) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random clients and controller, transaction-level model with scoreboard queues.
module tb_mem_port_arbiter;
  localparam int P = 4, AW = 32, DW = 32, MW = DW / 8;
  logic CLK = 0, RST = 1;
  logic [2*P-1:0] rw_flag;
  logic [AW*P-1:0] addr;
  logic [DW*P-1:0] write_data, read_data;
  logic [MW*P-1:0] write_mask;
  logic [P-1:0] busy, done;
  logic [1:0] m_rw_flag;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_write_data;
  logic [MW-1:0] m_write_mask;
  logic [DW-1:0] m_read_data = '0;
  logic m_busy = 0, m_done = 0;
`ifdef MEMARB_TIMEOUT_EN
  logic timeout_err;
`endif
  logic [1:0] c_rw [P];
  logic [AW-1:0] c_addr [P];
  logic [DW-1:0] c_wd [P];
  logic [MW-1:0] c_wm [P];
  int total = 0, bad = 0;
  bit auto_cl = 0, stall = 0, fixd = 0;
  int pct = 25, mb_mode = 0, ccnt = 0, cdly = 1;

  mem_port_arbiter #(.PORTS(P), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .rw_flag(rw_flag), .addr(addr), .write_data(write_data),
    .write_mask(write_mask), .read_data(read_data), .busy(busy), .done(done),
    .m_rw_flag(m_rw_flag), .m_addr(m_addr), .m_write_data(m_write_data),
    .m_write_mask(m_write_mask), .m_read_data(m_read_data), .m_busy(m_busy), .m_done(m_done)
`ifdef MEMARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int k = 0; k < P; k++) begin
      rw_flag[2*k +: 2] = c_rw[k];
      addr[AW*k +: AW] = c_addr[k];
      write_data[DW*k +: DW] = c_wd[k];
      write_mask[MW*k +: MW] = c_wm[k];
    end
  end

  task automatic chk(string nm, logic [DW*P-1:0] act, logic [DW*P-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < P; k++) if (c_rw[k] != 2'b00) return 1;
    return 0;
  endfunction

  // reference model: one transaction at a time, round-robin from the port after the last one served
  typedef struct { int port; logic [1:0] op; logic [AW-1:0] a; logic [DW-1:0] d; logic [MW-1:0] m; } iss_t;
  typedef struct { int port; logic [DW*P-1:0] rd; } dn_t;
  iss_t iss_q[$];
  dn_t dn_q[$];
  dn_t mon_e;
  int mst = 0, cur = 0, rr = 0;
  logic [DW-1:0] rd_m [P];
  logic [DW*P-1:0] flat;
  always @(posedge CLK) begin
    if (RST) begin
      mst = 0;
      rr = 0;
      iss_q.delete();
      dn_q.delete();
      for (int k = 0; k < P; k++) rd_m[k] = '0;
    end else if (mst == 0) begin
      if (!m_busy)
        for (int k = 0; k < P; k++)
          if (mst == 0 && ^c_rw[(rr + k) % P]) begin
            cur = (rr + k) % P;
            mst = 1;
            iss_q.push_back('{cur, c_rw[cur], c_addr[cur], c_wd[cur], c_wm[cur]});
          end
    end else if (mst == 1) begin
      if (m_done) begin
        if (iss_q[0].op == 2'b01) rd_m[cur] = m_read_data;
        for (int k = 0; k < P; k++) flat[DW*k +: DW] = rd_m[k];
        dn_q.push_back('{cur, flat});
        rr = (cur + 1) % P;
        mst = 2;
      end
    end else mst = 0;
  end

  initial forever begin
    @(negedge CLK);
    chk("onehot", {$onehot0(busy), $onehot0(done)}, 2'b11);
    if (m_rw_flag != 2'b00) begin
      if (iss_q.size() == 0) chk("unexpected_issue", m_rw_flag, 0);
      else begin
        chk("m_rw_flag", m_rw_flag, iss_q[0].op);
        chk("m_addr", m_addr, iss_q[0].a);
        chk("m_write_data", m_write_data, iss_q[0].d);
        chk("m_write_mask", m_write_mask, iss_q[0].m);
        chk("busy_grant", busy, 1 << iss_q[0].port);
      end
    end
    if (done != '0) begin
      if (dn_q.size() == 0) chk("unexpected_done", done, 0);
      else begin
        mon_e = dn_q.pop_front();
        chk("done_port", done, 1 << mon_e.port);
        chk("read_data", read_data, mon_e.rd);
        chk("busy_resp", busy, 0);
        chk("m_rw_flag_resp", m_rw_flag, 0);
        if (iss_q.size() != 0) void'(iss_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    for (int i = 0; i < P; i++) begin
      if (^c_rw[i]) begin
        if (done[i]) c_rw[i] = 2'b00;
      end else if (c_rw[i] == 2'b11) c_rw[i] = 2'b00;
      else if (auto_cl && $urandom_range(0, 99) < pct) begin
        c_rw[i] = $urandom_range(0, 9) == 0 ? 2'b11 : ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b10);
        c_addr[i] = $urandom;
        c_wd[i] = $urandom;
        c_wm[i] = MW'($urandom);
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    m_done = 0;
    if (m_rw_flag != 2'b00 && !stall) begin
      if (ccnt == 0) cdly = fixd ? 1 : $urandom_range(1, 4);
      if (ccnt == cdly) begin
        m_done = 1;
        m_read_data = fixd ? 32'hDEADBEEF : $urandom;
      end
      ccnt++;
    end else ccnt = 0;
  end

  initial forever begin
    @(negedge CLK);
    m_busy = mb_mode == 2 ? 1'b1 : (mb_mode == 1 && $urandom_range(0, 2) == 0);
  end

  task automatic drain();
    int n = 0;
    auto_cl = 0;
    while (n < 300 && (pending() || iss_q.size() != 0 || dn_q.size() != 0)) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_in_time", n < 300, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_m_rw_flag"}, m_rw_flag, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_write_data"}, m_write_data, 0);
    chk({tag, "_m_write_mask"}, m_write_mask, 0);
    chk({tag, "_read_data"}, read_data, 0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < P; k++) begin
      c_rw[k] = 2'b00; c_addr[k] = '0; c_wd[k] = '0; c_wm[k] = '0;
    end
    repeat (2) @(negedge CLK);
    chk_zero("reset");
    RST = 0;
    auto_cl = 1; mb_mode = 1; pct = 25;
    repeat (1500) @(negedge CLK);
    pct = 100; mb_mode = 0;
    repeat (500) @(negedge CLK);
    drain();
    // single read with m_done in the first WAIT cycle
    fixd = 1;
    c_addr[0] = 32'h100; c_wd[0] = 32'h0; c_wm[0] = 4'hF; c_rw[0] = 2'b01;
    n = 0;
    while (done[0] !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("req_to_done_cycles", n, 3);
    chk("read_data0", read_data[DW-1:0], 32'hDEADBEEF);
    fixd = 0;
    drain();
    // backpressure on port 2
    mb_mode = 2;
    @(negedge CLK);
    c_addr[2] = 32'h2004; c_wd[2] = 32'h12345678; c_wm[2] = 4'b0011; c_rw[2] = 2'b10;
    repeat (10) begin
      @(negedge CLK);
      chk("bp_m_rw_flag", m_rw_flag, 0);
      chk("bp_busy", busy, 0);
    end
    mb_mode = 0; m_busy = 0;
    @(negedge CLK);
    chk("bp_grant_busy", busy, 4'b0100);
    chk("bp_grant_op", m_rw_flag, 2'b10);
    drain();
    // reset while the controller withholds m_done
    stall = 1;
    c_addr[1] = 32'h40; c_rw[1] = 2'b01;
    n = 0;
    while (m_rw_flag == 2'b00 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("stall_issue_seen", n < 20, 1);
    repeat (2) @(negedge CLK);
    RST = 1;
    for (int k = 0; k < P; k++) c_rw[k] = 2'b00;
    @(negedge CLK);
    chk_zero("mid_reset");
    RST = 0; stall = 0;
    repeat (2) begin
      @(negedge CLK);
      chk("no_done_after_reset", done, 0);
    end
    for (int k = 0; k < P; k++) begin
      c_addr[k] = $urandom; c_wd[k] = $urandom; c_wm[k] = MW'($urandom); c_rw[k] = 2'b10;
    end
    @(negedge CLK);
    chk("post_reset_first_grant", busy, 4'b0001);
    drain();
    auto_cl = 1; mb_mode = 1; pct = 50;
    repeat (600) @(negedge CLK);
    drain();
    chk("issue_queue_empty", iss_q.size(), 0);
    chk("done_queue_empty", dn_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
